// File: rtl/csr_excp.sv
// rtl/csr_excp.sv - LoongArch-32 exception/interrupt CSR file with optional stable-counter timer
//
// Purpose: holds CRMD, PRMD, ECFG, ESTAT, ERA, BADV, EENTRY, SAVE0..SAVE(SAVE_N-1) and,
// when CSR_TIMER_EN is defined, TID, TCFG, TVAL, TICLR plus the timer counter. Records
// exceptions, restores state on ERTN and raises has_int for the pipeline.
// Without CSR_TIMER_EN the timer CSRs read 0, ignore writes and ESTAT.IS[11] is 0.
//
// Ports:
//   clk, resetn                  clock, synchronous active-low reset
//   csr_re/csr_rd_num            combinational read port -> csr_rd_value
//   csr_we/csr_wr_num/_mask/_value  masked write port
//   wb_ex/wb_ecode/wb_esubcode/wb_pc/wb_vaddr  exception commit from WB
//   ertn_flush                   ERTN commit from WB
//   hw_int_in/ipi_int_in         level interrupt lines
//   has_int, ex_entry, ertn_pc   interrupt request, exception entry PC, ERTN return PC
module csr_excp #(
   parameter int          SAVE_N   = 4,
   parameter int          HW_INT_N = 8,
   parameter int          TIMER_W  = 32,
   parameter logic [31:0] CORE_ID  = 32'h0
) (
   input  logic                clk,
   input  logic                resetn,
   input  logic                csr_re,
   input  logic [13:0]         csr_rd_num,
   output logic [31:0]         csr_rd_value,
   input  logic                csr_we,
   input  logic [13:0]         csr_wr_num,
   input  logic [31:0]         csr_wr_mask,
   input  logic [31:0]         csr_wr_value,
   input  logic                wb_ex,
   input  logic [5:0]          wb_ecode,
   input  logic [8:0]          wb_esubcode,
   input  logic [31:0]         wb_pc,
   input  logic [31:0]         wb_vaddr,
   input  logic                ertn_flush,
   input  logic [HW_INT_N-1:0] hw_int_in,
   input  logic                ipi_int_in,
   output logic                has_int,
   output logic [31:0]         ex_entry,
   output logic [31:0]         ertn_pc
);

   localparam logic [13:0] CSR_CRMD   = 14'h000;
   localparam logic [13:0] CSR_PRMD   = 14'h001;
   localparam logic [13:0] CSR_ECFG   = 14'h004;
   localparam logic [13:0] CSR_ESTAT  = 14'h005;
   localparam logic [13:0] CSR_ERA    = 14'h006;
   localparam logic [13:0] CSR_BADV   = 14'h007;
   localparam logic [13:0] CSR_EENTRY = 14'h00C;
   localparam logic [13:0] CSR_SAVE0  = 14'h030;
   localparam logic [13:0] CSR_TID    = 14'h040;
   localparam logic [13:0] CSR_TCFG   = 14'h041;
   localparam logic [13:0] CSR_TVAL   = 14'h042;
   localparam logic [13:0] CSR_TICLR  = 14'h044;

   logic [1:0]          plv_q, plv_d, pplv_q, pplv_d, swi_q, swi_d;
   logic                ie_q, ie_d, pie_q, pie_d, ipi_q;
   logic [12:0]         lie_q, lie_d;
   logic [HW_INT_N-1:0] hw_q;
   logic [5:0]          ecode_q, ecode_d;
   logic [8:0]          esub_q, esub_d;
   logic [31:0]         era_q, era_d, badv_q, badv_d;
   logic [25:0]         eentry_q, eentry_d;
   logic [31:0]         save_q [SAVE_N];
   logic [31:0]         save_d [SAVE_N];
   logic                ti_w;
   logic [31:0]         tid_rd, tcfg_rd, tval_rd;

   // Masked-write terms: new = mv | (mk & old) for every field.
   logic [31:0] mv, mk;
   assign mv = csr_wr_mask & csr_wr_value;
   assign mk = ~csr_wr_mask;

   logic wr_crmd, wr_prmd, wr_ecfg, wr_estat, wr_era, wr_badv, wr_eentry;
   assign wr_crmd   = csr_we && (csr_wr_num == CSR_CRMD);
   assign wr_prmd   = csr_we && (csr_wr_num == CSR_PRMD);
   assign wr_ecfg   = csr_we && (csr_wr_num == CSR_ECFG);
   assign wr_estat  = csr_we && (csr_wr_num == CSR_ESTAT);
   assign wr_era    = csr_we && (csr_wr_num == CSR_ERA);
   assign wr_badv   = csr_we && (csr_wr_num == CSR_BADV);
   assign wr_eentry = csr_we && (csr_wr_num == CSR_EENTRY);

   logic ex_adef, ex_ale;
   assign ex_adef = (wb_ecode == 6'h08) && (wb_esubcode == 9'h0);
   assign ex_ale  = (wb_ecode == 6'h09);

   always_comb begin
      plv_d = plv_q;   ie_d = ie_q;   pplv_d = pplv_q; pie_d = pie_q;
      lie_d = lie_q;   swi_d = swi_q; ecode_d = ecode_q; esub_d = esub_q;
      era_d = era_q;   badv_d = badv_q; eentry_d = eentry_q;
      for (int i = 0; i < SAVE_N; i++) save_d[i] = save_q[i];

      if (wb_ex) begin
         plv_d = 2'b00; ie_d = 1'b0;
      end else if (ertn_flush) begin
         plv_d = pplv_q; ie_d = pie_q;
      end else if (wr_crmd) begin
         plv_d = mv[1:0] | (mk[1:0] & plv_q);
         ie_d  = mv[2] | (mk[2] & ie_q);
      end

      if (wb_ex) begin
         pplv_d = plv_q; pie_d = ie_q;
      end else if (wr_prmd) begin
         pplv_d = mv[1:0] | (mk[1:0] & pplv_q);
         pie_d  = mv[2] | (mk[2] & pie_q);
      end

      if (wr_ecfg) lie_d = (mv[12:0] | (mk[12:0] & lie_q)) & 13'h1BFF;

      if (wb_ex) begin
         ecode_d = wb_ecode; esub_d = wb_esubcode;
      end else if (wr_estat) begin
         swi_d = mv[1:0] | (mk[1:0] & swi_q);
      end

      if (wb_ex)       era_d = wb_pc;
      else if (wr_era) era_d = mv | (mk & era_q);

      // BADV only belongs to the exception when the exception actually reports an address.
      if (wb_ex && ex_adef)     badv_d = wb_pc;
      else if (wb_ex && ex_ale) badv_d = wb_vaddr;
      else if (wr_badv)         badv_d = mv | (mk & badv_q);

      if (wr_eentry) eentry_d = mv[31:6] | (mk[31:6] & eentry_q);

      for (int i = 0; i < SAVE_N; i++)
         if (csr_we && (csr_wr_num == CSR_SAVE0 + 14'(i))) save_d[i] = mv | (mk & save_q[i]);
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         plv_q <= '0; ie_q <= 1'b0; pplv_q <= '0; pie_q <= 1'b0;
         lie_q <= '0; swi_q <= '0; hw_q <= '0; ipi_q <= 1'b0;
         ecode_q <= '0; esub_q <= '0; era_q <= '0; badv_q <= '0; eentry_q <= '0;
         for (int i = 0; i < SAVE_N; i++) save_q[i] <= '0;
      end else begin
         plv_q <= plv_d; ie_q <= ie_d; pplv_q <= pplv_d; pie_q <= pie_d;
         lie_q <= lie_d; swi_q <= swi_d; hw_q <= hw_int_in; ipi_q <= ipi_int_in;
         ecode_q <= ecode_d; esub_q <= esub_d; era_q <= era_d; badv_q <= badv_d;
         eentry_q <= eentry_d;
         for (int i = 0; i < SAVE_N; i++) save_q[i] <= save_d[i];
      end
   end

`ifdef CSR_TIMER_EN
   logic [31:0]        tid_q, tid_d;
   logic [TIMER_W-1:0] tcfg_q, tcfg_d, cnt_q, cnt_d;
   logic               ti_q, ti_d;
   logic               wr_tid, wr_tcfg, wr_ticlr;
   assign wr_tid   = csr_we && (csr_wr_num == CSR_TID);
   assign wr_tcfg  = csr_we && (csr_wr_num == CSR_TCFG);
   assign wr_ticlr = csr_we && (csr_wr_num == CSR_TICLR);

   always_comb begin
      tid_d = tid_q; tcfg_d = tcfg_q; cnt_d = cnt_q; ti_d = ti_q;
      if (wr_tid) tid_d = mv | (mk & tid_q);
      if (wr_ticlr && mv[0]) ti_d = 1'b0;
      // Expiry is evaluated after the clear so a simultaneous set wins.
      // All-ones is the parked value of a one-shot timer: it never decrements from there.
      if (tcfg_q[0] && (cnt_q == '0)) begin
         ti_d  = 1'b1;
         cnt_d = tcfg_q[1] ? {tcfg_q[TIMER_W-1:2], 2'b00} : '1;
      end else if (tcfg_q[0] && (cnt_q != '1)) begin
         cnt_d = cnt_q - TIMER_W'(1);
      end
      if (wr_tcfg) begin
         tcfg_d = mv[TIMER_W-1:0] | (mk[TIMER_W-1:0] & tcfg_q);
         cnt_d  = {tcfg_d[TIMER_W-1:2], 2'b00};
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         tid_q <= CORE_ID; tcfg_q <= '0; cnt_q <= '1; ti_q <= 1'b0;
      end else begin
         tid_q <= tid_d; tcfg_q <= tcfg_d; cnt_q <= cnt_d; ti_q <= ti_d;
      end
   end

   assign ti_w    = ti_q;
   assign tid_rd  = tid_q;
   assign tcfg_rd = 32'(tcfg_q);
   assign tval_rd = 32'(cnt_q);
`else
   assign ti_w    = 1'b0;
   assign tid_rd  = 32'h0;
   assign tcfg_rd = 32'h0;
   assign tval_rd = 32'h0;
`endif

   logic [7:0]  hw_pad;
   logic [12:0] is_w;
   assign hw_pad = 8'(hw_q);
   assign is_w   = {ipi_q, ti_w, 1'b0, hw_pad, swi_q};

   always_comb begin
      csr_rd_value = 32'h0;
      case (csr_rd_num)
         CSR_CRMD:   csr_rd_value = {27'h0, 2'b01, ie_q, plv_q};
         CSR_PRMD:   csr_rd_value = {29'h0, pie_q, pplv_q};
         CSR_ECFG:   csr_rd_value = {19'h0, lie_q};
         CSR_ESTAT:  csr_rd_value = {1'b0, esub_q, ecode_q, 3'b000, is_w};
         CSR_ERA:    csr_rd_value = era_q;
         CSR_BADV:   csr_rd_value = badv_q;
         CSR_EENTRY: csr_rd_value = {eentry_q, 6'h0};
         CSR_TID:    csr_rd_value = tid_rd;
         CSR_TCFG:   csr_rd_value = tcfg_rd;
         CSR_TVAL:   csr_rd_value = tval_rd;
         default:    csr_rd_value = 32'h0;
      endcase
      for (int i = 0; i < SAVE_N; i++)
         if (csr_rd_num == CSR_SAVE0 + 14'(i)) csr_rd_value = save_q[i];
      if (!csr_re) csr_rd_value = 32'h0;
   end

   assign has_int  = ie_q & (|(is_w & lie_q));
   assign ex_entry = {eentry_q, 6'h0};
   assign ertn_pc  = era_q;

endmodule

// File: doc/csr_excp.md
# csr_excp

Parametrised exception/interrupt CSR file for the LoongArch-32 pipeline, sitting beside the WB stage. Holds CRMD, PRMD, ECFG, ESTAT, ERA, BADV, EENTRY, SAVE0..SAVE(N-1), TID, TCFG, TVAL and TICLR. Records exceptions, handles ERTN, runs the stable-counter timer, and samples hardware, IPI and timer interrupt lines. Drives `has_int` back to the pipeline, plus the exception entry and return PCs.

## Interface
- `SAVE_N`, 4: number of SAVE registers, 1..16, at numbers 0x30+i.
- `HW_INT_N`, 8: hardware interrupt lines, 1..8, mapped to ESTAT.IS[2+i].
- `TIMER_W`, 32: timer counter width, 8..32.
- `CORE_ID`, 0: reset value of TID.
- `clk` in 1: clock.
- `resetn` in 1: reset, synchronous, active-low.
- `csr_re` in 1: read enable.
- `csr_rd_num` in 14: read CSR number.
- `csr_rd_value` out 32: read data, combinational.
- `csr_we` in 1: write enable.
- `csr_wr_num` in 14: write CSR number.
- `csr_wr_mask` in 32: per-bit write mask.
- `csr_wr_value` in 32: write data.
- `wb_ex` in 1: exception committing this cycle.
- `wb_ecode` in 6: exception code.
- `wb_esubcode` in 9: exception subcode.
- `wb_pc` in 32: PC of the excepting instruction.
- `wb_vaddr` in 32: faulting data address.
- `ertn_flush` in 1: ERTN committing this cycle.
- `hw_int_in` in HW_INT_N: level hardware interrupts.
- `ipi_int_in` in 1: inter-processor interrupt.
- `has_int` out 1: interrupt pending and enabled.
- `ex_entry` out 32: equals EENTRY.
- `ertn_pc` out 32: equals ERA.

## Operation
- Every masked write updates `new = mask&value | ~mask&old`, restricted to the register's writable bits. Unimplemented bits read 0. Unknown numbers read 0. `csr_re`=0 forces 0.
- Priority per register: `wb_ex` > `ertn_flush` > CSR write.
- CRMD: PLV[1:0], IE[2], DA[3] fixed 1, PG[4] fixed 0, DATF/DATM fixed 0.
  - Exception: PLV←0, IE←0.
  - ERTN: PLV←PRMD.PPLV, IE←PRMD.PIE.
- PRMD: PPLV[1:0], PIE[2]. Exception copies CRMD.PLV/IE into them. Both fields are writable.
- ECFG: LIE[12:0], write mask 0x1BFF.
- ESTAT:
  - IS[1:0] software-writable.
  - IS[2+i] is `hw_int_in[i]` registered each cycle.
  - IS[10] is 0. IS[11] is the timer flag. IS[12] is `ipi_int_in` registered.
  - Ecode[21:16] and EsubCode[30:22] load on `wb_ex` only.
- ERA: ←`wb_pc` on exception; writable.
- BADV: ←`wb_pc` when ecode=0x08 and esubcode=0 (ADEF); ←`wb_vaddr` when ecode=0x09 (ALE); writable.
- EENTRY: VA[31:6] writable, [5:0]=0.
- TID: writable, reset CORE_ID.
- TCFG: En[0], Periodic[1], InitVal[TIMER_W-1:2].
- Timer counter `cnt` (TIMER_W bits):
  - A TCFG write loads `cnt` ← {new InitVal, 2'b00}.
  - Otherwise, while En=1 and `cnt`≠all-ones, `cnt` decrements by 1 each cycle.
  - When `cnt`=0 with En=1: set IS[11]. Next `cnt` is the reload value if Periodic=1, else all-ones, which stops counting.
- TVAL: read-only, zero-extended `cnt`.
- TICLR: a write with mask[0]&value[0]=1 clears IS[11]. Reads as 0.
- `has_int` = CRMD.IE & |(ESTAT.IS[12:0] & ECFG.LIE[12:0]).

## Timing
- Reads are combinational. A write or event becomes visible on the read port the cycle after the edge. Read-during-write returns the old value.
- `hw_int_in`/`ipi_int_in` reach IS one cycle after the input changes; `has_int` follows combinationally from there.
- TCFG write at edge N with InitVal=k: TVAL reads 4k after N; IS[11] is set at edge N+4k+1.
- Timer expiry and a TICLR clear in the same cycle: the set wins.
- `wb_ex` and `ertn_flush` together: only the exception takes effect.
- A `wb_ex` cycle that also carries a CSR write to the same register: the exception update wins; the write is dropped.
- Reset values:
  - CRMD=0x8; PRMD, ECFG, IS, ERA, BADV, EENTRY, SAVEs, TCFG all 0.
  - `cnt` is all-ones; Ecode/EsubCode are 0; TID=CORE_ID.
  - `has_int`=0, `ex_entry`=0, `ertn_pc`=0.
- Reset asserted mid-count stops the timer and clears IS[11] on the same edge.

## Configuration
- `CSR_TIMER_EN` defined: TID, TCFG, TVAL, TICLR, `cnt` and IS[11] are implemented as above.
- Not defined: those four numbers read 0 and ignore writes, IS[11] is constant 0, and no counter logic is synthesised.

## Test plan
- Write CRMD value 0x7 mask 0x7, then `wb_ex` with ecode 0x0B, pc 0x1C000100: CRMD=0x8, PRMD=0x7, ERA=0x1C000100, ESTAT[21:16]=0x0B. Then `ertn_flush`: CRMD=0xF.
- `wb_ex` ecode 0x09, vaddr 0x00000123: BADV=0x123. ADEF with pc 0x1C000004: BADV=0x1C000004.
- TCFG ←0x0000000B (InitVal=2, periodic, en): IS[11] rises 9 cycles after the write; `cnt` reloads to 8. TICLR ←1 clears IS[11]. One-shot variant: TVAL holds 0xFFFFFFFF after expiry.
- ECFG ←0x800, CRMD.IE=1, timer expiry: `has_int`=1. IE=0: `has_int`=0. ECFG write value 0x1FFF reads 0x1BFF.
- `hw_int_in[3]`=1 with LIE[5]=1, IE=1: `has_int` rises 1 cycle later. ESTAT write 0xFFFFFFFF changes only IS[1:0].
- Simultaneous `wb_ex` and ERA write 0x55: ERA=`wb_pc`. Build without `CSR_TIMER_EN`: TVAL reads 0.
